// File: rtl/trivium_stream.sv
// Trivium stream cipher core: key/IV load, warm-up, then W keystream
// bits per cycle XORed onto a valid/ready word stream of programmed length.
`timescale 1ns/1ps
module trivium_stream #(
   parameter int W     = 8,
   parameter int LEN_W = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [79:0]      key,
   input  logic [79:0]      iv,
   input  logic [LEN_W-1:0] len,
   input  logic [W-1:0]     in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [W-1:0]     out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             done
);

   localparam int INIT_CYC = 1152 / W;
   localparam int IC_W     = 11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_INIT,
      S_RUN,
      S_DONE
   } state_e;

   state_e             state_q, state_d;
   logic [287:0]       st_q, st_d;
   logic [IC_W-1:0]    init_cnt_q, init_cnt_d;
   logic [LEN_W-1:0]   word_cnt_q, word_cnt_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [W-1:0]       out_data_q, out_data_d;
   logic               out_valid_q, out_valid_d;
   logic               done_q, done_d;

   logic [287:0]       st_adv;
   logic [W-1:0]       ks;
   logic               t1, t2, t3;
   logic               xfer_in;
   logic               last_out;
   logic               init_last;
   logic [287:0]       st_load;

   // bit s(i) of the cipher state lives at st[i-1]
   assign st_load = {3'b111, 112'd0, iv, 13'd0, key};

   assign xfer_in   = in_valid & in_ready;
   assign last_out  = (state_q == S_RUN) & out_valid_q & out_ready &
                      (word_cnt_q == len_q);
   assign init_last = (init_cnt_q == IC_W'(INIT_CYC - 1));

   // W unrolled rounds; round j produces keystream bit j
   always_comb begin
      st_adv = st_q;
      ks     = '0;
      t1     = 1'b0;
      t2     = 1'b0;
      t3     = 1'b0;
      for (int j = 0; j < W; j++) begin
         t1 = st_adv[65]  ^ st_adv[92];
         t2 = st_adv[161] ^ st_adv[176];
         t3 = st_adv[242] ^ st_adv[287];
         ks[j] = t1 ^ t2 ^ t3;
         t1 = t1 ^ (st_adv[90]  & st_adv[91])  ^ st_adv[170];
         t2 = t2 ^ (st_adv[174] & st_adv[175]) ^ st_adv[263];
         t3 = t3 ^ (st_adv[285] & st_adv[286]) ^ st_adv[68];
         st_adv = {st_adv[286:177], t2,
                   st_adv[175:93],  t1,
                   st_adv[91:0],    t3};
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // FSM next state; a zero-length message skips warm-up entirely
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) state_d = (len == '0) ? S_DONE : S_INIT;
         end
         S_INIT: begin
            if (init_last) state_d = S_RUN;
         end
         S_RUN: begin
            if (last_out) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs; input stops once the whole message is loaded
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      unique case (state_q)
         S_INIT: busy = 1'b1;
         S_RUN: begin
            busy     = 1'b1;
            in_ready = (~out_valid_q | out_ready) &
                       (word_cnt_q != len_q);
         end
         default: begin
            in_ready = 1'b0;
            busy     = 1'b0;
         end
      endcase
   end

   // datapath next values: load, warm-up advance, per-transfer advance
   always_comb begin
      st_d        = st_q;
      init_cnt_d  = init_cnt_q;
      word_cnt_d  = word_cnt_q;
      len_d       = len_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      done_d      = 1'b0;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            out_valid_d = 1'b0;
            if (start) begin
               st_d       = st_load;
               len_d      = len;
               init_cnt_d = '0;
               word_cnt_d = '0;
               done_d     = (len == '0);
            end
         end
         S_INIT: begin
            st_d       = st_adv;
            init_cnt_d = init_cnt_q + 1'b1;
         end
         S_RUN: begin
            if (xfer_in) begin
               st_d        = st_adv;
               out_data_d  = in_data ^ ks;
               out_valid_d = 1'b1;
               word_cnt_d  = word_cnt_q + 1'b1;
            end else if (out_ready) begin
               out_valid_d = 1'b0;
            end
            done_d = last_out;
         end
         default: out_valid_d = 1'b0;
      endcase
   end

   // datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         st_q        <= '0;
         init_cnt_q  <= '0;
         word_cnt_q  <= '0;
         len_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         st_q        <= st_d;
         init_cnt_q  <= init_cnt_d;
         word_cnt_q  <= word_cnt_d;
         len_q       <= len_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign done      = done_q;

endmodule

// File: tb/tb_trivium_stream.sv
// Directed bench for trivium_stream: W=8 main instance plus W=1/W=64
// instances, checked against a bit-serial Trivium reference model.
`timescale 1ns/1ps
module tb_trivium_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [79:0] key, iv;

   logic        start8;
   logic [11:0] len8;
   logic [7:0]  in8, out8;
   logic        in_valid8, in_ready8, out_valid8, out_ready8;
   logic        busy8, done8;

   logic        start_w, in_valid_w, out_ready_w;
   logic [11:0] len1, len64;
   logic        in1, out1, in_ready1, out_valid1, busy1, done1;
   logic [63:0] in64, out64;
   logic        in_ready64, out_valid64, busy64, done64;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   logic ks [0:1023];

   trivium_stream #(.W(8), .LEN_W(12)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .key(key), .iv(iv),
      .len(len8), .in_data(in8), .in_valid(in_valid8),
      .in_ready(in_ready8), .out_data(out8), .out_valid(out_valid8),
      .out_ready(out_ready8), .busy(busy8), .done(done8));

   trivium_stream #(.W(1), .LEN_W(12)) dut1 (
      .clk(clk), .reset(reset), .start(start_w), .key(key), .iv(iv),
      .len(len1), .in_data(in1), .in_valid(in_valid_w),
      .in_ready(in_ready1), .out_data(out1), .out_valid(out_valid1),
      .out_ready(out_ready_w), .busy(busy1), .done(done1));

   trivium_stream #(.W(64), .LEN_W(12)) dut64 (
      .clk(clk), .reset(reset), .start(start_w), .key(key), .iv(iv),
      .len(len64), .in_data(in64), .in_valid(in_valid_w),
      .in_ready(in_ready64), .out_data(out64), .out_valid(out_valid64),
      .out_ready(out_ready_w), .busy(busy64), .done(done64));

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // bit-serial reference using 1-based state numbering s[1..288]
   task automatic gen_ks(input logic [79:0] k, input logic [79:0] v,
                         input int nbits);
      logic s [1:288];
      logic a, b, c, z;
      for (int i = 1; i <= 288; i++) s[i] = 1'b0;
      for (int i = 1; i <= 80; i++) begin
         s[i]      = k[i-1];
         s[93 + i] = v[i-1];
      end
      s[286] = 1'b1;
      s[287] = 1'b1;
      s[288] = 1'b1;
      for (int r = 0; r < 1152 + nbits; r++) begin
         a = s[66] ^ s[93];
         b = s[162] ^ s[177];
         c = s[243] ^ s[288];
         z = a ^ b ^ c;
         a = a ^ (s[91] & s[92]) ^ s[171];
         b = b ^ (s[175] & s[176]) ^ s[264];
         c = c ^ (s[286] & s[287]) ^ s[69];
         for (int i = 288; i >= 2; i--) s[i] = s[i-1];
         s[1]   = c;
         s[94]  = a;
         s[178] = b;
         if (r >= 1152) ks[r - 1152] = z;
      end
   endtask

   function automatic logic [7:0] ksw8(input int i);
      logic [7:0] w;
      for (int j = 0; j < 8; j++) w[j] = ks[i*8 + j];
      return w;
   endfunction

   // one message through dut8; optional random flow, start glitches, abort
   task automatic run_msg(input logic [79:0] k, input logic [79:0] v,
                          input int n, input bit rnd, input bit glitch,
                          input int abort_at);
      logic [7:0] pt [0:255];
      logic [7:0] held, e;
      int tx, rx, cyc, lat, dones;
      bit stalled;
      gen_ks(k, v, n * 8);
      for (int i = 0; i < n; i++) pt[i] = rnd ? 8'($urandom) : 8'h00;
      key = k;
      iv = v;
      len8 = 12'(n);
      in_valid8 = 1'b0;
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b1;
      lat = 0;
      do begin
         @(posedge clk); #1;
         start8 = 1'b0;
         lat++;
         if (lat == 1) begin
            check("busy_init", 64'(busy8), 64'd1);
            if (glitch) begin
               key = ~k;
               iv = ~v;
               len8 = 12'd3;
            end
         end
         if (glitch && lat == 50) start8 = 1'b1;
      end while (!in_ready8 && lat < 2000);
      start8 = 1'b0;
      check("latency", 64'(lat), 64'd145);
      tx = 0; rx = 0; cyc = 0; dones = 0; stalled = 0; held = '0;
      while (cyc < 3000) begin
         start8 = (glitch && cyc == 20);
         in_valid8 = (tx < n) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
         in8 = (tx < n) ? pt[tx] : 8'h00;
         out_ready8 = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
         #1;
         if (stalled) begin
            check("stall_valid", 64'(out_valid8), 64'd1);
            check("stall_data", 64'(out8), 64'(held));
         end
         stalled = 0;
         if (out_valid8 && out_ready8) begin
            e = pt[rx] ^ ksw8(rx);
            check($sformatf("word%0d", rx), 64'(out8), 64'(e));
            rx++;
         end else if (out_valid8) begin
            stalled = 1;
            held = out8;
         end
         if (in_valid8 && in_ready8) tx++;
         @(posedge clk); #1;
         start8 = 1'b0;
         if (done8) dones++;
         if (abort_at >= 0 && rx == abort_at) break;
         if (rx == n) break;
         cyc++;
      end
      in_valid8 = 1'b0;
      out_ready8 = 1'b1;
      if (abort_at >= 0) begin
         reset = 1'b1;
         @(posedge clk); #1;
         check("abort_out_valid", 64'(out_valid8), 64'd0);
         check("abort_in_ready", 64'(in_ready8), 64'd0);
         check("abort_busy", 64'(busy8), 64'd0);
         check("abort_done", 64'(done8), 64'd0);
         check("abort_out_data", 64'(out8), 64'd0);
         reset = 1'b0;
      end else begin
         check("rx_count", 64'(rx), 64'(n));
         check("done_pulse", 64'(done8), 64'd1);
         check("done_once", 64'(dones), 64'd1);
         @(posedge clk); #1;
         check("done_clear", 64'(done8), 64'd0);
         check("done_busy", 64'(busy8), 64'd0);
         check("done_in_ready", 64'(in_ready8), 64'd0);
         check("done_out_valid", 64'(out_valid8), 64'd0);
      end
   endtask

   // same key/iv through W=1 and W=64 at full throughput
   task automatic run_wide(input logic [79:0] k, input logic [79:0] v);
      logic [511:0] got1, got64;
      logic [63:0] e;
      int cyc, lat1, lat64, n1, n64;
      gen_ks(k, v, 512);
      key = k;
      iv = v;
      len1 = 12'd512;
      len64 = 12'd8;
      in1 = 1'b0;
      in64 = '0;
      in_valid_w = 1'b1;
      out_ready_w = 1'b1;
      got1 = '0; got64 = '0;
      @(posedge clk); #1;
      start_w = 1'b1;
      cyc = 0; lat1 = -1; lat64 = -1; n1 = 0; n64 = 0;
      while (cyc < 3000 && !(n1 == 512 && n64 == 8)) begin
         @(posedge clk); #1;
         start_w = 1'b0;
         cyc++;
         if (in_ready1 && lat1 < 0) lat1 = cyc;
         if (in_ready64 && lat64 < 0) lat64 = cyc;
         if (out_valid1 && n1 < 512) begin
            got1[n1] = out1;
            n1++;
         end
         if (out_valid64 && n64 < 8) begin
            got64[n64*64 +: 64] = out64;
            n64++;
         end
      end
      check("w1_latency", 64'(lat1), 64'd1153);
      check("w64_latency", 64'(lat64), 64'd19);
      check("w1_count", 64'(n1), 64'd512);
      check("w64_count", 64'(n64), 64'd8);
      for (int c = 0; c < 8; c++) begin
         for (int b = 0; b < 64; b++) e[b] = ks[c*64 + b];
         check($sformatf("w1_chunk%0d", c), got1[c*64 +: 64], e);
         check($sformatf("w64_chunk%0d", c), got64[c*64 +: 64], e);
      end
      in_valid_w = 1'b0;
   endtask

   initial begin
      logic [79:0] k1, v1;
      k1 = 80'd0;
      v1 = 80'd1 << 79;
      reset = 1'b1;
      start8 = 1'b0; start_w = 1'b0;
      key = '0; iv = '0;
      len8 = '0; len1 = '0; len64 = '0;
      in8 = '0; in1 = 1'b0; in64 = '0;
      in_valid8 = 1'b0; out_ready8 = 1'b0;
      in_valid_w = 1'b0; out_ready_w = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid8), 64'd0);
      check("rst_in_ready", 64'(in_ready8), 64'd0);
      check("rst_busy", 64'(busy8), 64'd0);
      check("rst_done", 64'(done8), 64'd0);
      check("rst_out_data", 64'(out8), 64'd0);
      reset = 1'b0;

      run_msg(k1, v1, 64, 1'b0, 1'b0, -1);
      run_msg(k1, v1, 64, 1'b0, 1'b0, 10);
      run_msg(k1, v1, 64, 1'b0, 1'b0, -1);
      run_msg(k1, v1, 64, 1'b0, 1'b1, -1);
      run_msg(80'h0123_4567_89ab_cdef_fedc, 80'h5a5a_0f0f_3c3c_9966_a5c3,
              100, 1'b1, 1'b0, -1);

      len8 = 12'd0;
      @(posedge clk); #1;
      start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      check("len0_done", 64'(done8), 64'd1);
      check("len0_busy", 64'(busy8), 64'd0);
      check("len0_out_valid", 64'(out_valid8), 64'd0);
      @(posedge clk); #1;
      check("len0_done_clear", 64'(done8), 64'd0);
      check("len0_out_valid2", 64'(out_valid8), 64'd0);

      run_msg(80'hffee_ddcc_bbaa_9988_7766, 80'h1111_2222_3333_4444_5555,
              1, 1'b1, 1'b0, -1);

      run_wide(k1, v1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
